// File: rtl/conversor_bcd_if.sv
// Processor-to-display bus for the BCD converter: OUT strobe and data in,
// four BCD digits plus status flags out.
interface conversor_bcd_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  sinal_out;
  logic [DATA_WIDTH-1:0] entrada_modulo;
  logic [3:0]            dp1;
  logic [3:0]            dp2;
  logic [3:0]            dp3;
  logic [3:0]            dp4;
  logic                  valido;
  logic                  ocupado;
  logic                  estouro;
  logic                  pendente;

  // Processor side drives the strobe and value and reads the display.
  modport master (
    output sinal_out, entrada_modulo,
    input  dp1, dp2, dp3, dp4, valido, ocupado, estouro, pendente
  );

  // Converter side.
  modport slave (
    input  sinal_out, entrada_modulo,
    output dp1, dp2, dp3, dp4, valido, ocupado, estouro, pendente
  );
endinterface

// File: rtl/conversor_bcd.sv
// Binary-to-BCD display converter using serial double dabble.
// Handshake: sinal_out is a one-cycle strobe sampled on every rising edge;
// in OCIOSO it starts a conversion, otherwise it lands in a one-deep
// last-wins pending register. valido pulses for one cycle after dp1..dp4
// and estouro update; ocupado is high whenever the FSM is not idle.
module conversor_bcd #(
  parameter int DATA_WIDTH = 32,
  parameter int BITS_CONV  = 14
) (
  input  logic                clock,
  input  logic                reset,
  conversor_bcd_if.slave      bus,
  output logic [1:0]          estado
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  localparam int CW = $clog2(BITS_CONV + 1);
  localparam logic [DATA_WIDTH-1:0] LIMITE = DATA_WIDTH'(9999);
  localparam logic [CW-1:0]         ULTIMO = CW'(BITS_CONV - 1);

  estado_t                 st, st_n;
  logic [BITS_CONV-1:0]    sr;
  logic [15:0]             acc;
  logic [CW-1:0]           cnt;
  logic                    ovf;
  logic [DATA_WIDTH-1:0]   pend_val;
  logic                    pend;
  logic [3:0]              dig1, dig2, dig3, dig4;
  logic                    val_q, est_q;

  logic                    start, pend_wr, pend_clr, step, publish;
  logic [DATA_WIDTH-1:0]   start_val;
  logic [16+BITS_CONV-1:0] junto;

  // Add 3 to every nibble that is 5 or more before the shift.
  function automatic logic [15:0] ajusta(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign junto = {ajusta(acc), sr};

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) st <= OCIOSO;
    else        st <= st_n;
  end

  // Next state and datapath controls; a start picks CONVERTE or jumps to FIM on overflow.
  always_comb begin
    st_n      = st;
    start     = 1'b0;
    start_val = bus.entrada_modulo;
    pend_wr   = bus.sinal_out && (st != OCIOSO);
    pend_clr  = 1'b0;
    step      = 1'b0;
    publish   = 1'b0;
    case (st)
      OCIOSO: begin
        if (bus.sinal_out) begin
          start    = 1'b1;
          pend_clr = 1'b1;
        end else if (pend) begin
          start     = 1'b1;
          start_val = pend_val;
          pend_clr  = 1'b1;
        end
      end
      CONVERTE: begin
        step = 1'b1;
        if (cnt == ULTIMO) st_n = FIM;
      end
      FIM: begin
        publish = 1'b1;
        if (pend) begin
          start     = 1'b1;
          start_val = pend_val;
          pend_clr  = 1'b1;
        end else begin
          st_n = OCIOSO;
        end
      end
      default: st_n = OCIOSO;
    endcase
    if (start) st_n = (start_val > LIMITE) ? FIM : CONVERTE;
  end

  // Conversion datapath: load on start, one double-dabble step per cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      if (start_val > LIMITE) begin
        acc <= 16'h9999;
        ovf <= 1'b1;
      end else begin
        sr  <= start_val[BITS_CONV-1:0];
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
    end else if (step) begin
      acc <= junto[16+BITS_CONV-2 : BITS_CONV-1];
      sr  <= {junto[BITS_CONV-2:0], 1'b0};
      cnt <= cnt + CW'(1);
    end
  end

  // One-deep pending request; a fresh strobe always wins over a clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_val <= '0;
      pend     <= 1'b0;
    end else if (pend_wr) begin
      pend_val <= bus.entrada_modulo;
      pend     <= 1'b1;
    end else if (pend_clr) begin
      pend <= 1'b0;
    end
  end

  // Display registers update only on the FIM edge; valido follows for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dig1  <= '0;
      dig2  <= '0;
      dig3  <= '0;
      dig4  <= '0;
      est_q <= 1'b0;
      val_q <= 1'b0;
    end else begin
      val_q <= publish;
      if (publish) begin
        dig1  <= acc[3:0];
        dig2  <= acc[7:4];
        dig3  <= acc[11:8];
        dig4  <= acc[15:12];
        est_q <= ovf;
      end
    end
  end

  assign bus.dp1      = dig1;
  assign bus.dp2      = dig2;
  assign bus.dp3      = dig3;
  assign bus.dp4      = dig4;
  assign bus.valido   = val_q;
  assign bus.estouro  = est_q;
  assign bus.pendente = pend;
  assign bus.ocupado  = (st != OCIOSO);
  assign estado       = st;

endmodule

// File: tb/tb_conversor_bcd.sv
// Bench for conversor_bcd: vector table plus hand sequences for pending,
// FIM-strobe and reset-abort cases, checked through an expected-value queue.
module tb_conversor_bcd;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] valor;
    logic [15:0]   bcd;
    logic          ovf;
    int            lat;
  } vetor_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] estado;

  conversor_bcd_if #(.DATA_WIDTH(DW)) bus ();

  conversor_bcd #(.DATA_WIDTH(DW), .BITS_CONV(14)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .estado (estado)
  );

  // Clock.
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, got, want, $time);
    end
  endtask

  function automatic logic [15:0] para_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Scoreboard: every valido pulse must match the oldest expected display.
  always @(negedge clock) begin
    if (reset && bus.valido === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valido: got dp=%h%h%h%h expected no pulse at %0t",
                 bus.dp4, bus.dp3, bus.dp2, bus.dp1, $time);
      end else begin
        check("display", {15'd0, bus.estouro, bus.dp4, bus.dp3, bus.dp2, bus.dp1},
              {15'd0, exp_q.pop_front()});
      end
    end
  end

  // Drive a one-cycle strobe; returns #1 after the sampling edge.
  task automatic strobe(input logic [DW-1:0] v);
    bus.sinal_out      = 1'b1;
    bus.entrada_modulo = v;
    @(posedge clock);
    #1;
    bus.sinal_out = 1'b0;
  endtask

  // Count edges until valido is seen at a negedge; returns at that negedge.
  task automatic wait_valido(input int limite, output int n);
    n = 0;
    do begin
      @(posedge clock);
      n++;
      @(negedge clock);
    end while (bus.valido !== 1'b1 && n < limite);
    if (bus.valido !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_valido: got no pulse expected one within %0d cycles", limite);
    end
  endtask

  task automatic realinha();
    @(posedge clock);
    #1;
  endtask

  vetor_t tabela[$];
  int     n;

  initial begin
    bus.sinal_out      = 1'b0;
    bus.entrada_modulo = '0;

    tabela.push_back('{32'd1234,       16'h1234, 1'b0, 15});
    tabela.push_back('{32'd0,          16'h0000, 1'b0, 15});
    tabela.push_back('{32'd9999,       16'h9999, 1'b0, 15});
    tabela.push_back('{32'd10000,      16'h9999, 1'b1, 1});
    tabela.push_back('{32'hFFFF_FFFF,  16'h9999, 1'b1, 1});
    tabela.push_back('{32'd1,          16'h0001, 1'b0, 15});
    tabela.push_back('{32'd5678,       16'h5678, 1'b0, 15});
    tabela.push_back('{32'h0001_0005,  16'h9999, 1'b1, 1});
    tabela.push_back('{32'd8090,       16'h8090, 1'b0, 15});
    for (int i = 0; i < 6; i++) begin
      int v;
      v = $urandom_range(0, 12000);
      if (v > 9999) tabela.push_back('{DW'(v), 16'h9999, 1'b1, 1});
      else          tabela.push_back('{DW'(v), para_bcd(v), 1'b0, 15});
    end

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("rst_dp",      {16'd0, bus.dp4, bus.dp3, bus.dp2, bus.dp1}, 32'd0);
    check("rst_flags",   {28'd0, bus.valido, bus.ocupado, bus.estouro, bus.pendente}, 32'd0);
    check("rst_estado",  {30'd0, estado}, 32'd0);
    reset = 1'b1;
    realinha();

    // Table-driven conversions.
    foreach (tabela[i]) begin
      exp_q.push_back({tabela[i].ovf, tabela[i].bcd});
      strobe(tabela[i].valor);
      wait_valido(40, n);
      check($sformatf("latency_%0d", tabela[i].valor), n, tabela[i].lat);
      check("ocupado_fall", {31'd0, bus.ocupado}, 32'd0);
      @(negedge clock);
      check("valido_one_cycle", {31'd0, bus.valido}, 32'd0);
      realinha();
    end

    // Two strobes during CONVERTE: last one wins, starts on the FIM edge.
    exp_q.push_back({1'b0, 16'h0042});
    exp_q.push_back({1'b0, 16'h0815});
    strobe(32'd42);
    realinha();
    strobe(32'd7);
    @(negedge clock);
    check("pendente_set", {31'd0, bus.pendente}, 32'd1);
    realinha();
    strobe(32'd815);
    @(negedge clock);
    check("pendente_hold", {31'd0, bus.pendente}, 32'd1);
    wait_valido(40, n);
    check("pend_clear", {31'd0, bus.pendente}, 32'd0);
    check("pend_busy", {31'd0, bus.ocupado}, 32'd1);
    wait_valido(40, n);
    check("pend_gap", n, 15);
    check("pend_idle", {31'd0, bus.ocupado}, 32'd0);
    realinha();

    // Strobe during FIM with nothing pending: buffered, started on the next edge.
    exp_q.push_back({1'b0, 16'h0300});
    exp_q.push_back({1'b0, 16'h0077});
    strobe(32'd300);
    repeat (14) @(posedge clock);
    #1;
    check("fim_state", {30'd0, estado}, 32'd2);
    strobe(32'd77);
    @(negedge clock);
    check("fim_buffer", {31'd0, bus.pendente}, 32'd1);
    check("fim_exit_idle", {31'd0, bus.ocupado}, 32'd0);
    wait_valido(40, n);
    check("fim_strobe_lat", n, 16);
    realinha();

    // Reset in the middle of a conversion aborts it without a valido pulse.
    strobe(32'd5678);
    repeat (7) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("abort_dp", {16'd0, bus.dp4, bus.dp3, bus.dp2, bus.dp1}, 32'd0);
    check("abort_flags", {28'd0, bus.valido, bus.ocupado, bus.estouro, bus.pendente}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (30) @(negedge clock);
    check("abort_idle", {30'd0, estado}, 32'd0);
    realinha();
    exp_q.push_back({1'b0, 16'h5678});
    strobe(32'd5678);
    wait_valido(40, n);
    check("after_reset_lat", n, 15);
    realinha();

    repeat (3) @(posedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
